ray_scanner: RTL and testbench

Sequential, parametrised board scanner for the move-generation path. Given a packed board, an origin square, a direction and a mode, it walks the board one square per clock along a sliding ray (rook/bishop/queen/king) or takes a single knight jump. It reports the first occupied square hit, or the last empty square reached, using a start/busy/done handshake. It generalises the fixed 8x8 single-jump knight lookup: board size and piece width are parameters, and sliding rays and step limits are supported.

---
 rtl/chess_scan_pkg.sv | 69 ++++++
 rtl/ray_scanner_if.sv | 36 +++
 rtl/ray_step.sv | 40 ++++
 rtl/ray_scanner.sv | 116 +++++++++++
 tb/tb_ray_scanner.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/chess_scan_pkg.sv
`default_nettype none
// ============================================================================
// chess_scan_pkg : direction/mode codes and ray deltas shared by board scanners
// revision 1.0
// ============================================================================
package chess_scan_pkg;

  localparam int EMPTY = 0;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_NE = 3'd1,
    DIR_E  = 3'd2,
    DIR_SE = 3'd3,
    DIR_S  = 3'd4,
    DIR_SW = 3'd5,
    DIR_W  = 3'd6,
    DIR_NW = 3'd7
  } dir_e;

  typedef enum logic {
    MODE_SLIDE  = 1'b0,
    MODE_KNIGHT = 1'b1
  } mode_e;

  typedef struct packed {
    logic signed [2:0] df;
    logic signed [2:0] dr;
  } delta_t;

  localparam logic signed [2:0] D_Z  = 3'sd0;
  localparam logic signed [2:0] D_P1 = 3'sd1;
  localparam logic signed [2:0] D_P2 = 3'sd2;
  localparam logic signed [2:0] D_M1 = -3'sd1;
  localparam logic signed [2:0] D_M2 = -3'sd2;

  function automatic delta_t mk_delta(input logic signed [2:0] df, input logic signed [2:0] dr);
    return {df, dr};
  endfunction

  // Rank 0 is the top edge, so "north" decreases the rank.
  function automatic delta_t slide_delta(input logic [2:0] dir);
    case (dir)
      DIR_N:   return mk_delta(D_Z,  D_M1);
      DIR_NE:  return mk_delta(D_P1, D_M1);
      DIR_E:   return mk_delta(D_P1, D_Z);
      DIR_SE:  return mk_delta(D_P1, D_P1);
      DIR_S:   return mk_delta(D_Z,  D_P1);
      DIR_SW:  return mk_delta(D_M1, D_P1);
      DIR_W:   return mk_delta(D_M1, D_Z);
      default: return mk_delta(D_M1, D_M1);
    endcase
  endfunction

  function automatic delta_t knight_delta(input logic [2:0] dir);
    case (dir)
      3'd0:    return mk_delta(D_M2, D_M1);
      3'd1:    return mk_delta(D_M1, D_M2);
      3'd2:    return mk_delta(D_P1, D_M2);
      3'd3:    return mk_delta(D_P2, D_M1);
      3'd4:    return mk_delta(D_P2, D_P1);
      3'd5:    return mk_delta(D_P1, D_P2);
      3'd6:    return mk_delta(D_M1, D_P2);
      default: return mk_delta(D_M2, D_P1);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ray_scanner_if.sv
`default_nettype none
// ============================================================================
// ray_scanner_if : start/busy/done request and result bundle of ray_scanner
// revision 1.0
// ============================================================================
interface ray_scanner_if #(
  parameter int FILES   = 8,
  parameter int RANKS   = 8,
  parameter int PIECE_W = 4,
  parameter int SQ_W    = $clog2(FILES*RANKS),
  parameter int STEP_W  = $clog2((FILES > RANKS) ? FILES : RANKS)
);
  logic                         start;
  logic [FILES*RANKS*PIECE_W-1:0] board;
  logic [SQ_W-1:0]              origin;
  logic [2:0]                   direction;
  logic                         mode;
  logic [STEP_W-1:0]            max_steps;
  logic                         busy;
  logic                         done;
  logic                         hit_found;
  logic [SQ_W-1:0]              hit_pos;
  logic [PIECE_W-1:0]           hit_piece;
  logic [STEP_W-1:0]            hit_steps;

  modport master (
    output start, board, origin, direction, mode, max_steps,
    input  busy, done, hit_found, hit_pos, hit_piece, hit_steps
  );

  modport slave (
    input  start, board, origin, direction, mode, max_steps,
    output busy, done, hit_found, hit_pos, hit_piece, hit_steps
  );
endinterface
`default_nettype wire

// File: rtl/ray_step.sv
`default_nettype none
// ============================================================================
// ray_step : one ray/knight step on file/rank coordinates with edge detection
// revision 1.0
// ============================================================================
module ray_step
  import chess_scan_pkg::*;
#(
  parameter int FILES = 8,
  parameter int RANKS = 8,
  parameter int SQ_W  = $clog2(FILES*RANKS)
) (
  input  logic [SQ_W-1:0] cur,
  input  logic [2:0]      direction,
  input  logic            mode,
  output logic [SQ_W-1:0] next,
  output logic            off_board
);
  // Two spare bits give a sign and headroom for FILES/RANKS themselves.
  localparam int CW = SQ_W + 2;
  localparam logic signed [CW-1:0] F_LIM = CW'(FILES);
  localparam logic signed [CW-1:0] R_LIM = CW'(RANKS);
  localparam logic [SQ_W:0]        N_SQ  = (SQ_W+1)'(FILES*RANKS);

  delta_t                 d;
  logic [SQ_W-1:0]        cf, cr;
  logic signed [CW-1:0]   nf, nr;

  always_comb begin
    d  = (mode == MODE_KNIGHT) ? knight_delta(direction) : slide_delta(direction);
    cf = SQ_W'(int'(cur) % FILES);
    cr = SQ_W'(int'(cur) / FILES);
    nf = $signed({2'b00, cf}) + CW'(d.df);
    nr = $signed({2'b00, cr}) + CW'(d.dr);
    off_board = ({1'b0, cur} >= N_SQ) || nf[CW-1] || (nf >= F_LIM)
                || nr[CW-1] || (nr >= R_LIM);
    next = SQ_W'(int'(nr) * FILES + int'(nf));
  end
endmodule
`default_nettype wire

// File: rtl/ray_scanner.sv
`default_nettype none
// ============================================================================
// ray_scanner : walks a latched board one square per clock along a ray/jump
// revision 1.0
// ============================================================================
module ray_scanner
  import chess_scan_pkg::*;
#(
  parameter int FILES   = 8,
  parameter int RANKS   = 8,
  parameter int PIECE_W = 4,
  parameter int SQ_W    = $clog2(FILES*RANKS),
  parameter int STEP_W  = $clog2((FILES > RANKS) ? FILES : RANKS)
) (
  input logic        clk,
  input logic        rst_n,
  ray_scanner_if.slave bus
);
  localparam int BOARD_W = FILES*RANKS*PIECE_W;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  state_e               state, state_nx;
  logic [BOARD_W-1:0]   board_q;
  logic [SQ_W-1:0]      cur;
  logic [STEP_W-1:0]    cnt, max_q, cnt_inc;
  logic [2:0]           dir_q;
  logic                 mode_q;
  logic [SQ_W-1:0]      nxt;
  logic                 off_board;
  logic [PIECE_W-1:0]   piece_at;
  logic                 term_hit, term_lim;
  logic                 found_q;
  logic [SQ_W-1:0]      pos_q;
  logic [PIECE_W-1:0]   piece_q;
  logic [STEP_W-1:0]    steps_q;

  ray_step #(.FILES(FILES), .RANKS(RANKS), .SQ_W(SQ_W)) u_step (
    .cur       (cur),
    .direction (dir_q),
    .mode      (mode_q),
    .next      (nxt),
    .off_board (off_board)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    cnt_inc  = cnt + 1'b1;
    piece_at = PIECE_W'(board_q >> (int'(nxt) * PIECE_W));
    term_hit = !off_board && (piece_at != PIECE_W'(EMPTY));
    term_lim = !off_board && ((mode_q == MODE_KNIGHT) ||
                              ((max_q != '0) && (cnt_inc == max_q)));
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SCAN;
      SCAN:    if (off_board || term_hit || term_lim) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_q <= '0;
      cur     <= '0;
      cnt     <= '0;
      max_q   <= '0;
      dir_q   <= '0;
      mode_q  <= 1'b0;
      found_q <= 1'b0;
      pos_q   <= '0;
      piece_q <= '0;
      steps_q <= '0;
    end else if (state == IDLE && bus.start) begin
      board_q <= bus.board;
      cur     <= bus.origin;
      cnt     <= '0;
      max_q   <= bus.max_steps;
      dir_q   <= bus.direction;
      mode_q  <= bus.mode;
    end else if (state == SCAN) begin
      // Priority matters: an occupied square wins over the step limit.
      if (off_board) begin
        found_q <= 1'b0;
        pos_q   <= cur;
        piece_q <= '0;
        steps_q <= cnt;
      end else if (term_hit) begin
        found_q <= 1'b1;
        pos_q   <= nxt;
        piece_q <= piece_at;
        steps_q <= cnt_inc;
      end else if (term_lim) begin
        found_q <= 1'b0;
        pos_q   <= nxt;
        piece_q <= '0;
        steps_q <= cnt_inc;
      end else begin
        cur <= nxt;
        cnt <= cnt_inc;
      end
    end
  end

  assign bus.hit_found = found_q;
  assign bus.hit_pos   = pos_q;
  assign bus.hit_piece = piece_q;
  assign bus.hit_steps = steps_q;
endmodule
`default_nettype wire

// File: tb/tb_ray_scanner.sv
`default_nettype none
// ============================================================================
// tb_ray_scanner : random and directed scans checked against a ray-walk model
// revision 1.0
// ============================================================================
module tb_ray_scanner;
  localparam int FILES = 8;
  localparam int RANKS = 8;
  localparam int PW    = 4;
  localparam int NSQ   = FILES*RANKS;
  localparam int BW    = NSQ*PW;

  localparam int SDF[8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};
  localparam int SDR[8] = '{-1, -1,  0,  1,  1,  1,  0, -1};
  localparam int KDF[8] = '{-2, -1,  1,  2,  2,  1, -1, -2};
  localparam int KDR[8] = '{-1, -2, -2, -1,  1,  2,  2,  1};

  typedef struct {
    bit found;
    int pos;
    int piece;
    int steps;
    int k;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  ray_scanner_if #(.FILES(FILES), .RANKS(RANKS), .PIECE_W(PW)) bus ();

  ray_scanner #(.FILES(FILES), .RANKS(RANKS), .PIECE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Walk the ray square by square; k is the SCAN cycle in which it ends.
  function automatic res_t model(input logic [BW-1:0] b, input int o, input int d,
                                 input int m, input int ms);
    res_t r;
    int f, rk, nf, nr, n, p;
    r.found = 0; r.pos = o; r.piece = 0; r.steps = 0; r.k = 1;
    if (o >= NSQ) return r;
    f = o % FILES; rk = o / FILES; n = 0;
    for (int i = 0; i < 2*NSQ; i++) begin
      nf = f  + (m != 0 ? KDF[d] : SDF[d]);
      nr = rk + (m != 0 ? KDR[d] : SDR[d]);
      if (nf < 0 || nf >= FILES || nr < 0 || nr >= RANKS) begin
        r.pos = rk*FILES + f; r.steps = n; r.k = n + 1;
        return r;
      end
      n++;
      p = int'(b[(nr*FILES + nf)*PW +: PW]);
      if (p != 0) begin
        r.found = 1; r.pos = nr*FILES + nf; r.piece = p; r.steps = n; r.k = n;
        return r;
      end
      if (m != 0 || (ms != 0 && n == ms)) begin
        r.pos = nr*FILES + nf; r.steps = n; r.k = n;
        return r;
      end
      f = nf; rk = nr;
    end
    return r;
  endfunction

  // Cycle-level expectation: phase 0 idle, 1 scanning, 2 done pulse.
  int   ph = 0;
  int   left = 0;
  res_t er = '{0, 0, 0, 0, 0};
  res_t pend = '{0, 0, 0, 0, 0};

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",  bus.busy,      ph != 0);
      chk("done",  bus.done,      ph == 2);
      chk("found", bus.hit_found, er.found);
      chk("pos",   bus.hit_pos,   er.pos);
      chk("piece", bus.hit_piece, er.piece);
      chk("steps", bus.hit_steps, er.steps);
      if (!rst_n) begin
        ph = 0;
        er = '{0, 0, 0, 0, 0};
      end else begin
        case (ph)
          0: if (bus.start) begin
               pend = model(bus.board, int'(bus.origin), int'(bus.direction),
                            int'(bus.mode), int'(bus.max_steps));
               left = pend.k;
               ph = 1;
             end
          1: begin
               left--;
               if (left == 0) begin ph = 2; er = pend; end
             end
          default: ph = 0;
        endcase
      end
    end
  end

  // Called at accept edge + 1. poke > 0: pulse start and alter the board on
  // that cycle; poke < 0: leave start untouched.
  task automatic wait_done(input int poke, output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.origin = 6'd20;
        bus.board[23:20] = 4'h7;
      end else if (poke >= 0) begin
        bus.start = 1'b0;
      end
    end
    if (bus.done !== 1'b1) chk("timeout", 0, 1);
  endtask

  task automatic launch(input logic [BW-1:0] b, input int o, input int d,
                        input int m, input int ms);
    @(posedge clk); #2;
    bus.board = b; bus.origin = 6'(o); bus.direction = 3'(d);
    bus.mode = 1'(m); bus.max_steps = 3'(ms); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic chk_res(input string nm, input int f, input int p, input int pc, input int s);
    chk({nm, "_found"}, bus.hit_found, f);
    chk({nm, "_pos"},   bus.hit_pos,   p);
    chk({nm, "_piece"}, bus.hit_piece, pc);
    chk({nm, "_steps"}, bus.hit_steps, s);
  endtask

  task automatic directed(input string nm, input logic [BW-1:0] b, input int o, input int d,
                          input int m, input int ms, input int f, input int p,
                          input int pc, input int s, input int el);
    int lat;
    launch(b, o, d, m, ms);
    wait_done(0, lat);
    chk({nm, "_lat"}, lat, el);
    chk_res(nm, f, p, pc, s);
  endtask

  initial begin
    logic [BW-1:0] b;
    int lat;
    bus.start = 1'b0; bus.board = '0; bus.origin = '0;
    bus.direction = '0; bus.mode = 1'b0; bus.max_steps = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    b = '0; b[3:0] = 4'h3;
    directed("nw_hit", b, 27, 7, 0, 0, 1, 0, 3, 3, 4);
    b = '0;
    directed("e_edge", b, 7, 2, 0, 0, 0, 7, 0, 0, 2);
    b = '0; b[16*PW +: PW] = 4'h9;
    directed("no_wrap", b, 15, 2, 0, 0, 0, 15, 0, 0, 2);
    b = '0; b[10*PW +: PW] = 4'h5;
    directed("kn_hit", b, 0, 4, 1, 0, 1, 10, 5, 1, 2);
    b = '0;
    directed("kn_off", b, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    directed("s_lim1", b, 27, 4, 0, 1, 0, 35, 0, 1, 2);
    directed("s_free", b, 27, 4, 0, 0, 0, 59, 0, 4, 6);

    // Start pulse and board change while busy must not disturb the scan.
    launch('0, 0, 2, 0, 0);
    wait_done(3, lat);
    chk("busy_lat", lat, 9);
    chk_res("busy_ign", 0, 7, 0, 7);

    // Reset in the middle of a scan.
    b = '0; b[63*PW +: PW] = 4'hA;
    launch(b, 0, 3, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk_res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    b = '0; b[3:0] = 4'h3;
    directed("post_rst", b, 27, 7, 0, 0, 1, 0, 3, 3, 4);

    // Start held high: the second request is taken the cycle after done.
    @(posedge clk); #2;
    b = '0; b[3:0] = 4'h3;
    bus.board = b; bus.origin = 6'd27; bus.direction = 3'd7;
    bus.mode = 1'b0; bus.max_steps = 3'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(-1, lat);
    chk("b2b1_lat", lat, 4);
    chk_res("b2b1", 1, 0, 3, 3);
    b = '0; b[10*PW +: PW] = 4'h5;
    bus.board = b; bus.origin = 6'd0; bus.direction = 3'd4; bus.mode = 1'b1;
    @(posedge clk); #1;
    chk("b2b_idle", bus.busy, 0);
    @(posedge clk); #1;
    chk("b2b_acc", bus.busy, 1);
    bus.start = 1'b0;
    wait_done(0, lat);
    chk("b2b2_lat", lat, 2);
    chk_res("b2b2", 1, 10, 5, 1);

    // Random scans on sparse boards; the compare process does the checking.
    for (int n = 0; n < 150; n++) begin
      b = '0;
      for (int s = 0; s < NSQ; s++)
        if ($urandom_range(0, 5) == 0) b[s*PW +: PW] = 4'($urandom_range(1, 15));
      launch(b, $urandom_range(0, NSQ-1), $urandom_range(0, 7),
             ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 7));
      wait_done(0, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
